// File: rtl/serial_addsub_unit.sv
// serial_addsub_unit: digit-serial adder/subtractor.
// Operands are consumed DIGIT bits per clock, LSB first, through a registered
// carry. Sum, carry/no-borrow, signed overflow and zero are reported through a
// start/busy/done handshake. Result outputs hold between operations.
module serial_addsub_unit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] part;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   digit_sum;
  logic [WIDTH-1:0] digit_wide;
  logic [WIDTH-1:0] part_next;
  logic             msb_cin;
  logic             last_digit;

  // One digit of the carry chain plus the partial result it would produce.
  // The current digit's sum enters the partial result from the MSB side, so
  // after N digits the full result is aligned at bit 0.
  always_comb begin
    digit_sum  = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
               + {{DIGIT{1'b0}}, carry};
    digit_wide = '0;
    digit_wide[DIGIT-1:0] = digit_sum[DIGIT-1:0];
    part_next  = (part >> DIGIT) | (digit_wide << (WIDTH - DIGIT));
    // Carry into the MSB recovered from the MSB's sum bit and its operands.
    msb_cin    = digit_sum[DIGIT-1] ^ a_sh[DIGIT-1] ^ b_sh[DIGIT-1];
    last_digit = (cnt == CW'(N - 1));
  end

  // Control FSM, operand shifters and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      part  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            part  <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          carry <= digit_sum[DIGIT];
          part  <= part_next;
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          cnt   <= cnt + CW'(1);
          if (last_digit) begin
            // Result registers load on the same edge that enters DONE.
            sum   <= part_next;
            cout  <= digit_sum[DIGIT];
            ovf   <= digit_sum[DIGIT] ^ msb_cin;
            zero  <= (part_next == '0);
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Scoreboard bench for serial_addsub_unit at WIDTH=8/DIGIT=1 and WIDTH=16/DIGIT=4.
module tb_serial_addsub_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit, 1 bit per clock
  logic        rst8, start8, sub8, busy8, done8, cout8, ovf8, zero8;
  logic [7:0]  a8, b8, sum8;
  // 16-bit, 4 bits per clock
  logic        rst16, start16, sub16, busy16, done16, cout16, ovf16, zero16;
  logic [15:0] a16, b16, sum16;

  serial_addsub_unit #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
  );

  serial_addsub_unit #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst16), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16), .zero(zero16)
  );

  int checks = 0;
  int errors = 0;

  // {sum, cout, ovf, zero}
  logic [10:0] q8[$];
  logic [18:0] q16[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compares every done pulse against the oldest expected result.
  initial begin
    logic [10:0] e8;
    logic [18:0] e16;
    forever begin
      @(negedge clk);
      if (done8 === 1'b1) begin
        chk("busy8_during_done", int'(busy8), 1);
        checks++;
        if (q8.size() == 0) begin
          errors++;
          $display("FAIL done8_unexpected: got done with sum=%0d, expected no done", sum8);
        end else begin
          e8 = q8.pop_front();
          if ({sum8, cout8, ovf8, zero8} !== e8) begin
            errors++;
            $display("FAIL res8: got sum=%0d cout=%0b ovf=%0b zero=%0b expected sum=%0d cout=%0b ovf=%0b zero=%0b",
                     sum8, cout8, ovf8, zero8, e8[10:3], e8[2], e8[1], e8[0]);
          end
        end
      end
      if (done16 === 1'b1) begin
        checks++;
        if (q16.size() == 0) begin
          errors++;
          $display("FAIL done16_unexpected: got done with sum=%0h, expected no done", sum16);
        end else begin
          e16 = q16.pop_front();
          if ({sum16, cout16, ovf16, zero16} !== e16) begin
            errors++;
            $display("FAIL res16: got sum=%0h cout=%0b ovf=%0b zero=%0b expected sum=%0h cout=%0b ovf=%0b zero=%0b",
                     sum16, cout16, ovf16, zero16, e16[18:3], e16[2], e16[1], e16[0]);
          end
        end
      end
    end
  end

  task automatic wait_done8(input string name, input int exp_lat);
    int n;
    n = 1;
    while (done8 !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk(name, n, exp_lat);
  endtask

  task automatic op8(input logic s, input logic [7:0] av, input logic [7:0] bv,
                     input logic [7:0] es, input logic ec, input logic eo, input logic ez);
    q8.push_back({es, ec, eo, ez});
    @(posedge clk); #1;
    start8 = 1'b1; sub8 = s; a8 = av; b8 = bv;
    @(posedge clk); #1;
    start8 = 1'b0;
    // operand changes after acceptance must not matter
    a8 = 8'($urandom); b8 = 8'($urandom); sub8 = ~s;
    wait_done8("lat8", 9);
  endtask

  task automatic op16(input logic s, input logic [15:0] av, input logic [15:0] bv,
                      input logic [15:0] es, input logic ec, input logic eo, input logic ez);
    int n;
    q16.push_back({es, ec, eo, ez});
    @(posedge clk); #1;
    start16 = 1'b1; sub16 = s; a16 = av; b16 = bv;
    @(posedge clk); #1;
    start16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom);
    n = 1;
    while (done16 !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("lat16", n, 5);
  endtask

  task automatic count_done8(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    int de[$];
    int e;
    rst8 = 1'b1; start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    rst16 = 1'b1; start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst8 = 1'b0; rst16 = 1'b0;

    chk("rst8_busy", int'(busy8), 0);
    chk("rst8_done", int'(done8), 0);
    chk("rst8_sum", int'(sum8), 0);
    chk("rst8_cout", int'(cout8), 0);
    chk("rst8_ovf", int'(ovf8), 0);
    chk("rst8_zero", int'(zero8), 1);
    chk("rst16_sum", int'(sum16), 0);
    chk("rst16_zero", int'(zero16), 1);
    chk("rst16_busy", int'(busy16), 0);

    // directed vectors: sub, a, b, sum, cout, ovf, zero
    op8(1'b0, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0, 1'b0);
    op8(1'b0, 8'd100, 8'd100, 8'd200, 1'b0, 1'b1, 1'b0);
    op8(1'b0, 8'd127, 8'd1,   8'd128, 1'b0, 1'b1, 1'b0);
    op8(1'b1, 8'd5,   8'd7,   8'd254, 1'b0, 1'b0, 1'b0);
    op8(1'b1, 8'd7,   8'd7,   8'd0,   1'b1, 1'b0, 1'b1);
    op8(1'b1, 8'd128, 8'd1,   8'd127, 1'b1, 1'b1, 1'b0);
    op8(1'b1, 8'd0,   8'd128, 8'd128, 1'b0, 1'b1, 1'b0);
    op8(1'b0, 8'd255, 8'd255, 8'd254, 1'b1, 1'b0, 1'b0);
    op8(1'b0, 8'd0,   8'd0,   8'd0,   1'b0, 1'b0, 1'b1);

    // outputs hold through the next op's RUN
    @(posedge clk); #1;
    chk("hold_idle_sum", int'(sum8), 0);
    op8(1'b0, 8'd60, 8'd40, 8'd100, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    start8 = 1'b1; sub8 = 1'b0; a8 = 8'd1; b8 = 8'd1;
    @(posedge clk); #1;
    start8 = 1'b0;
    q8.push_back({8'd2, 1'b0, 1'b0, 1'b0});
    repeat (3) @(posedge clk);
    #1;
    chk("hold_run_sum", int'(sum8), 100);
    chk("hold_run_busy", int'(busy8), 1);
    // start pulsed mid-RUN with other operands is ignored
    start8 = 1'b1; sub8 = 1'b1; a8 = 8'd99; b8 = 8'd99;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8("lat8_ignore", 5);
    count_done8(15, nd);
    chk("ignored_start_extra_done", nd, 0);

    // reset 4 cycles into RUN discards the op
    @(posedge clk); #1;
    start8 = 1'b1; sub8 = 1'b0; a8 = 8'd9; b8 = 8'd9;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst8 = 1'b1;
    @(posedge clk); #1;
    rst8 = 1'b0;
    chk("midrst_busy", int'(busy8), 0);
    chk("midrst_sum", int'(sum8), 0);
    chk("midrst_zero", int'(zero8), 1);
    chk("midrst_done", int'(done8), 0);
    count_done8(15, nd);
    chk("midrst_no_done", nd, 0);

    // start held high for 30 cycles: one op per 10 cycles
    repeat (3) q8.push_back({8'd7, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1;
    start8 = 1'b1; sub8 = 1'b0; a8 = 8'd3; b8 = 8'd4;
    e = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      e++;
      if (done8 === 1'b1) de.push_back(e);
    end
    start8 = 1'b0;
    chk("held_done_count", de.size(), 3);
    if (de.size() == 3) begin
      chk("held_first_done", de[0], 9);
      chk("held_period_1", de[1] - de[0], 10);
      chk("held_period_2", de[2] - de[1], 10);
    end
    repeat (12) @(posedge clk);

    // 16-bit, 4 bits per clock
    op16(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
    op16(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
    op16(1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1);
    op16(1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    op16(1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    chk("q8_drained", q8.size(), 0);
    chk("q16_drained", q16.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
